codec_sequencer: RTL and testbench

// - Sequences the BRAM -> delta encoder -> decoder -> averaging filter chain from one start request.
// - Issues BRAM reads and a programmable-rate sample strobe that advances the codec/filter delay registers.
// - Flushes the filter pipeline and flags which filtered outputs are real samples.
// - Sits between the board buttons and the codec datapath in the top level.

---
 rtl/codec_sequencer.sv | 163 ++++++++++++++++
 tb/tb_codec_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_sequencer.sv
// codec_sequencer: plays BRAM addresses 0..len into the delta codec / averaging
// filter chain at a programmable sample rate, flushes the filter pipeline and
// marks which filtered outputs carry real samples.
// Build option: define SEQ_LOOP_EN for continuous looped playback (no drain/done).
//
// state | meaning
// IDLE  | waiting for a start edge, outputs quiet
// PRIME | one cycle for the first BRAM read to land
// RUN   | strobing samples, stepping through BRAM addresses
// DRAIN | address held, strobing until the filter pipeline empties
// DONE  | playback finished, waiting for a restart
module codec_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DIV_W    = 16,
  parameter int PIPE_LAT = 4
) (
  input  logic              CLK100MHZ,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic [ADDR_W-1:0] len_cfg,
  output logic              bram_ena,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              sample_en,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt
);

  localparam int PL_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic              start_s1, start_s2, start_d;
  logic              start_pulse;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [ADDR_W-1:0] len_q;
  logic [PL_W-1:0]   primed;
  logic              strobe_tc;
  logic              pipe_full;
`ifndef SEQ_LOOP_EN
  localparam logic [ADDR_W:0] CNT_MAX = '1;
  logic [PL_W-1:0]   drain;
`endif

  assign start_pulse = start_s2 & ~start_d;
  assign strobe_tc   = (div_cnt == div_q);
  assign pipe_full   = (primed == PL_W'(PIPE_LAT));

  // Two-flop synchronizer for the button plus a delay flop for edge detection.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_q      <= '0;
      div_cnt    <= '0;
      len_q      <= '0;
      primed     <= '0;
`ifndef SEQ_LOOP_EN
      drain      <= '0;
`endif
      bram_ena   <= 1'b0;
      bram_addr  <= '0;
      sample_en  <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
    end else begin
      sample_en <= 1'b0;
      out_valid <= 1'b0;
      if (abort) begin
        // abort outranks a coincident start edge; sample_cnt keeps its value
        state     <= IDLE;
        bram_ena  <= 1'b0;
        bram_addr <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_pulse) begin
              div_q      <= div_cfg;
              len_q      <= len_cfg;
              bram_addr  <= '0;
              bram_ena   <= 1'b1;
              sample_cnt <= '0;
              primed     <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
              state      <= PRIME;
            end
          end
          PRIME: begin
            div_cnt <= '0;
            state   <= RUN;
          end
          RUN, DRAIN: begin
            if (strobe_tc) begin
              div_cnt   <= '0;
              sample_en <= 1'b1;
              // the first PIPE_LAT strobes only fill the filter pipeline
              if (pipe_full) begin
                out_valid <= 1'b1;
`ifdef SEQ_LOOP_EN
                sample_cnt <= sample_cnt + 1'b1;
`else
                if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
`endif
              end else begin
                primed <= primed + 1'b1;
              end
              if (state == RUN) begin
                if (bram_addr != len_q) begin
                  bram_addr <= bram_addr + 1'b1;
                end else begin
`ifdef SEQ_LOOP_EN
                  bram_addr <= '0;
`else
                  drain <= PL_W'(PIPE_LAT);
                  state <= DRAIN;
`endif
                end
              end
`ifndef SEQ_LOOP_EN
              else begin
                if (drain == PL_W'(1)) begin
                  drain    <= '0;
                  bram_ena <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
                end else begin
                  drain <= drain - 1'b1;
                end
              end
`endif
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_sequencer.sv
// Bench for codec_sequencer: stimulus pushes the expected strobe stream into a
// scoreboard queue, a monitor pops one entry per sample_en strobe and compares.
module tb_codec_sequencer;
  localparam int ADDR_W   = 8;
  localparam int DIV_W    = 16;
  localparam int PIPE_LAT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DIV_W-1:0]  div_cfg = '0;
  logic [ADDR_W-1:0] len_cfg = '0;
  logic              bram_ena;
  logic [ADDR_W-1:0] bram_addr;
  logic              sample_en;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sample_cnt;

  codec_sequencer #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK100MHZ (clk),
    .reset_n   (rst_n),
    .start     (start),
    .abort     (abort),
    .div_cfg   (div_cfg),
    .len_cfg   (len_cfg),
    .bram_ena  (bram_ena),
    .bram_addr (bram_addr),
    .sample_en (sample_en),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int valid;
    int cnt;
    int gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per strobe; gap is clocks since the previous
  // strobe (or since the start pin rose for the first strobe of a run).
  always @(negedge clk) begin
    if (sample_en === 1'b1) begin
      check("strobe_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("strobe_addr", int'(bram_addr), mon_e.addr);
        check("strobe_valid", int'(out_valid), mon_e.valid);
        check("strobe_cnt", int'(sample_cnt), mon_e.cnt);
        if (mon_e.gap != 0) check("strobe_gap", cyc - t_ref, mon_e.gap);
      end
      t_ref = cyc;
    end else if (out_valid === 1'b1) begin
      check("valid_needs_strobe", int'(out_valid), int'(sample_en));
    end
  end

  // Expected strobe k of a run: address already stepped, valid after the
  // pipeline fill, first strobe lands 5+div clocks after the start pin rises.
  task automatic push_run(input int div, input int len, input int n, input bit loop_mode);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.addr  = loop_mode ? (k % (len + 1)) : ((k < len) ? k : len);
      e.valid = (k > PIPE_LAT) ? 1 : 0;
      e.cnt   = (k > PIPE_LAT) ? k - PIPE_LAT : 0;
      e.gap   = (k == 1) ? 5 + div : div + 1;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit set_ref);
    @(negedge clk);
    start = 1'b1;
    if (set_ref) t_ref = cyc;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    check("done_reached", int'(done), 1);
    @(negedge clk);
  endtask

  task automatic wait_addr(input int a, input int budget);
    for (int i = 0; i < budget && int'(bram_addr) != a; i++) @(negedge clk);
    check("addr_reached", int'(bram_addr), a);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ena"}, int'(bram_ena), 0);
    check({tag, "_addr"}, int'(bram_addr), 0);
    check({tag, "_sample_en"}, int'(sample_en), 0);
  endtask

  initial begin
    bit seen_done;
    repeat (3) @(negedge clk);
    check("rst_ena", int'(bram_ena), 0);
    check("rst_sample_en", int'(sample_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_cnt", int'(sample_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("idle");

`ifndef SEQ_LOOP_EN
    // basic run: 8 addresses, 12 strobes every 4 clocks, 8 valid
    div_cfg = 16'd3; len_cfg = 8'd7;
    push_run(3, 7, 12, 1'b0);
    pulse_start(1'b1);
    check("run_busy", int'(busy), 1);
    check("run_ena", int'(bram_ena), 1);
    div_cfg = 16'd0; len_cfg = 8'd1;
    wait_done(300);
    check("run_sb_empty", sb.size(), 0);
    check("run_final_cnt", int'(sample_cnt), 8);
    check("run_final_addr", int'(bram_addr), 7);
    check("run_final_ena", int'(bram_ena), 0);
    check("run_final_busy", int'(busy), 0);

    // fastest rate, single address
    div_cfg = 16'd0; len_cfg = 8'd0;
    push_run(0, 0, 5, 1'b0);
    pulse_start(1'b1);
    wait_done(100);
    check("min_sb_empty", sb.size(), 0);
    check("min_cnt", int'(sample_cnt), 1);
    check("min_done", int'(done), 1);

    // abort coincident with a start edge at addr 3
    div_cfg = 16'd3; len_cfg = 8'd7;
    push_run(3, 7, 3, 1'b0);
    pulse_start(1'b1);
    wait_addr(3, 100);
    start = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_quiet("abort3");
    check("abort3_done", int'(done), 0);
    check("abort3_cnt", int'(sample_cnt), 0);
    repeat (12) @(negedge clk);
    check("abort3_no_restart", int'(busy), 0);
    check("abort3_sb_empty", sb.size(), 0);

    // abort late enough that sample_cnt is nonzero and must hold
    push_run(3, 7, 6, 1'b0);
    pulse_start(1'b1);
    wait_addr(6, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_quiet("abort6");
    check("abort6_cnt", int'(sample_cnt), 2);
    repeat (6) @(negedge clk);
    check("abort6_sb_empty", sb.size(), 0);

    // start during RUN is ignored, then a restart from DONE
    div_cfg = 16'd1; len_cfg = 8'd5;
    push_run(1, 5, 10, 1'b0);
    pulse_start(1'b1);
    wait_addr(2, 60);
    div_cfg = 16'd7; len_cfg = 8'd2;
    pulse_start(1'b0);
    wait_done(100);
    check("ign_sb_empty", sb.size(), 0);
    check("ign_cnt", int'(sample_cnt), 6);
    div_cfg = 16'd1; len_cfg = 8'd5;
    push_run(1, 5, 10, 1'b0);
    pulse_start(1'b1);
    check("restart_done", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_addr", int'(bram_addr), 0);
    check("restart_cnt", int'(sample_cnt), 0);
    wait_done(100);
    check("restart_sb_empty", sb.size(), 0);
    check("restart_final_cnt", int'(sample_cnt), 6);

    // asynchronous reset mid-run
    div_cfg = 16'd3; len_cfg = 8'd7;
    push_run(3, 7, 5, 1'b0);
    pulse_start(1'b1);
    wait_addr(5, 100);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("areset");
    check("areset_done", int'(done), 0);
    check("areset_valid", int'(out_valid), 0);
    check("areset_cnt", int'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_quiet("post_reset");
    check("post_reset_sb_empty", sb.size(), 0);
`else
    // looped playback: addresses wrap, done never rises, abort stops it
    div_cfg = 16'd1; len_cfg = 8'd3;
    push_run(1, 3, 12, 1'b1);
    seen_done = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("loop_sb_empty", sb.size(), 0);
    check("loop_done_seen", int'(seen_done), 0);
    check_quiet("loop_abort");
    check("loop_cnt", int'(sample_cnt), 8);
    repeat (8) @(negedge clk);
    check("loop_stays_idle", int'(busy), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
